// File: rtl/shift_rows_pipe_pkg.sv
// shift_rows_pipe_pkg: byte geometry and row-offset helpers shared by the ShiftRows pipeline
package shift_rows_pipe_pkg;
  localparam int BYTE_W = 8;
  localparam int ROWS = 4;
  function automatic int shift_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction
  function automatic int byte_lsb(input int nb, input int r, input int c);
    return ROWS * BYTE_W * nb - BYTE_W - BYTE_W * (ROWS * c + r);
  endfunction
endpackage

// File: rtl/shift_rows_pipe_if.sv
// shift_rows_pipe_if: valid/ready beat of state + tag; carries the direction bit when SHIFT_ROWS_INV_EN is defined
interface shift_rows_pipe_if #(
  parameter int NB = 4,
  parameter int TAG_W = 4
);
  logic valid;
  logic ready;
  logic [32*NB-1:0] data;
  logic [TAG_W-1:0] tag;
`ifdef SHIFT_ROWS_INV_EN
  logic inv;
  modport master(output valid, data, tag, inv, input ready);
  modport slave(input valid, data, tag, inv, output ready);
`else
  modport master(output valid, data, tag, input ready);
  modport slave(input valid, data, tag, output ready);
`endif
endinterface

// File: rtl/shift_rows_pipe_perm.sv
// shift_rows_pipe_perm: combinational ShiftRows byte permutation; inverse selectable when SHIFT_ROWS_INV_EN is defined
module shift_rows_pipe_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
`ifdef SHIFT_ROWS_INV_EN
  input  logic             inv,
`endif
  output logic [32*NB-1:0] shifted
);
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_F = (c + shift_offset(NB, r)) % NB;
`ifdef SHIFT_ROWS_INV_EN
      localparam int SRC_I = (c - shift_offset(NB, r) + NB) % NB;
      assign shifted[byte_lsb(NB, r, c) +: BYTE_W] = inv ? data[byte_lsb(NB, r, SRC_I) +: BYTE_W]
                                                         : data[byte_lsb(NB, r, SRC_F) +: BYTE_W];
`else
      assign shifted[byte_lsb(NB, r, c) +: BYTE_W] = data[byte_lsb(NB, r, SRC_F) +: BYTE_W];
`endif
    end
  end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: ShiftRows ahead of a STAGES-deep valid/ready register chain; inverse mode under SHIFT_ROWS_INV_EN
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4,
  parameter int STAGES = 1,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  shift_rows_pipe_if.slave  up,
  shift_rows_pipe_if.master dn
);
  localparam int W = 32 * NB;
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..3");
  end
  logic [W-1:0] perm;
  logic [STAGES:0] rdy;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] src_v;
  logic [W-1:0] d [STAGES];
  logic [W-1:0] src_d [STAGES];
  logic [TAG_W-1:0] t [STAGES];
  logic [TAG_W-1:0] src_t [STAGES];
  shift_rows_pipe_perm #(.NB(NB)) u_perm (
    .data(up.data),
`ifdef SHIFT_ROWS_INV_EN
    .inv(up.inv),
`endif
    .shifted(perm)
  );
  assign rdy[STAGES] = dn.ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_link
    assign rdy[k] = !v[k] | rdy[k+1];
    if (k == 0) begin : g_head
      assign src_v[k] = up.valid;
      assign src_d[k] = perm;
      assign src_t[k] = up.tag;
    end else begin : g_tail
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
      assign src_t[k] = t[k-1];
    end
  end
  // a stage takes its upstream beat whenever it is empty or its own beat moves on this cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
        t[k] <= '0;
      end
    end else
      for (int k = 0; k < STAGES; k++)
        if (rdy[k]) begin
          v[k] <= src_v[k];
          d[k] <= src_d[k];
          t[k] <= src_t[k];
        end
  assign up.ready = rdy[0];
  assign dn.valid = v[STAGES-1];
  assign dn.data = d[STAGES-1];
  assign dn.tag = t[STAGES-1];
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed and random checks of three pipeline configurations against a byte-level ShiftRows model
module tb_shift_rows_pipe;
  typedef struct packed {
    logic [255:0] d;
    logic [3:0]   t;
  } beat_t;
  logic clk;
  logic rst;
  logic iv [3];
  logic ordy [3];
  logic ir [3];
  logic ov [3];
  logic [255:0] od [3];
  logic [3:0] ot [3];
  logic [255:0] din;
  logic [255:0] a_beat;
  logic [3:0] tin;
  logic inv_b;
  beat_t q [3][$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] x, input logic inv);
    int off8 [4] = '{0, 1, 3, 4};
    logic [7:0] b [4][8];
    logic [255:0] o;
    int w, sh;
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        b[r][c] = x[w-8-8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8) ? off8[r] : r;
      for (int c = 0; c < nb; c++)
        o[w-8-8*(4*c+r) +: 8] = b[r][inv ? (c - sh + nb) % nb : (c + sh) % nb];
    end
    return o;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int NB = (i == 0) ? 4 : (i == 1) ? 8 : 6;
    beat_t e;
    shift_rows_pipe_if #(.NB(NB), .TAG_W(4)) up ();
    shift_rows_pipe_if #(.NB(NB), .TAG_W(4)) dn ();
    assign up.valid = iv[i];
    assign up.data = din[32*NB-1:0];
    assign up.tag = tin;
`ifdef SHIFT_ROWS_INV_EN
    assign up.inv = inv_b;
    assign dn.inv = 1'b0;
`endif
    assign dn.ready = ordy[i];
    assign ir[i] = up.ready;
    assign ov[i] = dn.valid;
    assign od[i] = 256'(dn.data);
    assign ot[i] = dn.tag;
    shift_rows_pipe #(.NB(NB), .STAGES(i + 1), .TAG_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .up(up),
      .dn(dn)
    );
    always @(negedge clk)
      if (rst) q[i].delete();
      else begin
        if (ov[i] && ordy[i]) begin
          chk("sb_pending", 256'(q[i].size() > 0), 256'd1);
          if (q[i].size() > 0) begin
            e = q[i].pop_front();
            chk("sb_data", od[i], e.d);
            chk("sb_tag", 256'(ot[i]), 256'(e.t));
          end
        end
        if (iv[i] && ir[i]) q[i].push_back('{d: ref_sr(NB, din, inv_b), t: tin});
      end
  end

  initial begin
    rst = 1'b1;
    din = '0;
    tin = '0;
    inv_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0;
      ordy[j] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk("rst_out_valid", 256'(ov[j]), 256'd0);
      chk("rst_out_data", od[j], 256'd0);
      chk("rst_in_ready", 256'(ir[j]), 256'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    din = {128'h0, 128'hd42711aee0bf98f1b8b45de51e415230};
    tin = 4'h5;
    iv[0] = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 256'(ir[0]), 256'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 256'(ov[0]), 256'd1);
    chk("t1_out_data", od[0], {128'h0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
    chk("t1_out_tag", 256'(ot[0]), 256'h5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_single_beat", 256'(ov[0]), 256'd0);
`ifdef SHIFT_ROWS_INV_EN
    @(posedge clk); #1;
    din = {128'h0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tin = 4'h9;
    inv_b = 1'b1;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      inv_b = j[0];
      for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
      @(negedge clk);
      chk("t2_stream_valid", 256'(ov[0]), 256'd1);
      if (j == 0) chk("t2_inv_vec", od[0], {128'h0, 128'hd42711aee0bf98f1b8b45de51e415230});
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    inv_b = 1'b0;
    repeat (2) @(posedge clk);
`endif
    @(posedge clk); #1;
    din = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    tin = 4'h2;
    iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("t3_latency_two", 256'(ov[1]), 256'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_nb8_valid", 256'(ov[1]), 256'd1);
    chk("t3_nb8_col0", 256'(od[1][255:224]), 256'h00050e13);
    @(posedge clk); #1;
    din = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t3_nb4_col0", 256'(od[0][127:96]), 256'h00050a0f);
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
    a_beat = din;
    tin = 4'h1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
    tin = 4'h2;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
    tin = 4'h3;
    @(negedge clk);
    chk("t4_full_in_ready", 256'(ir[1]), 256'd0);
    chk("t4_head_data", od[1], ref_sr(8, a_beat, 1'b0));
    chk("t4_head_tag", 256'(ot[1]), 256'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_still_full", 256'(ir[1]), 256'd0);
    chk("t4_data_stable", od[1], ref_sr(8, a_beat, 1'b0));
    @(posedge clk); #1;
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("t4_pass_through_ready", 256'(ir[1]), 256'd1);
    chk("t4_order_1", 256'(ot[1]), 256'h1);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("t4_order_2", 256'(ot[1]), 256'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_order_3", 256'(ot[1]), 256'h3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_drained", 256'(ov[1]), 256'd0);
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("t5_in_flight", 256'(ov[1]), 256'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 256'(ov[1]), 256'd0);
    chk("t5_rst_data", od[1], 256'd0);
    chk("t5_rst_tag", 256'(ot[1]), 256'd0);
    chk("t5_rst_ready", 256'(ir[1]), 256'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale", 256'(ov[1]), 256'd0);
    end
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        iv[j] = $urandom_range(0, 3) != 0;
        ordy[j] = $urandom_range(0, 2) != 0;
      end
      for (int k = 0; k < 8; k++) din[32*k +: 32] = $urandom;
      tin = 4'($urandom);
`ifdef SHIFT_ROWS_INV_EN
      inv_b = 1'($urandom);
`endif
    end
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0;
      ordy[j] = 1'b1;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk("stress_no_loss", 256'(q[j].size()), 256'd0);
      chk("stress_idle", 256'(ov[j]), 256'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
